digit_entry_reg: RTL and testbench
==================================

# digit_entry_reg

Parametrised digit-entry register for the Input Unit, successor to the plain nibble shift register. Holds up to COUNT digits of WIDTH bits and accepts push, pop (backspace), parallel load and clear commands. Tracks the significant-digit count, rejects illegal digits and over/underflow, and supports leading-zero suppression. Sits between the keypad decoder and the operand latches feeding the ALU.

## Interface
- COUNT, 4: number of digit slots.
- WIDTH, 4: bits per digit.
- RADIX, 10: legal digit values are 0..RADIX-1; RADIX <= 2**WIDTH.
- LZ_SUPPRESS, 1: 1 = pushing 0 into an empty register is absorbed.
- trig  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is present this cycle.
- cmd  input  2  command code (package enum): PUSH=0, POP=1, LOAD=2, CLEAR=3.
- dir  input  1  entry direction; sampled only on CLEAR. 0 = digits enter at LSD, 1 = digits enter at MSD.
- digit  input  WIDTH  digit for PUSH.
- load_val  input  COUNT*WIDTH  word for LOAD.
- out  output  COUNT*WIDTH  digit word; slot 0 = bits [WIDTH-1:0].
- count  output  $clog2(COUNT+1)  significant digits held.
- empty  output  1  count == 0.
- full  output  1  count == COUNT.
- ack  output  1  one-cycle pulse: the command was accepted.
- err  output  1  one-cycle pulse: the command was rejected; state is unchanged.

## Operation
- Internal mode register holds the latched dir. Reset: out=0, count=0, mode=0, empty=1, full=0, ack=0, err=0.
- At most one command per cycle. The command is ignored when cmd_valid=0. ack and err are never both high.
- PUSH, mode 0: out <= (out << WIDTH) | digit; count+1.
- PUSH, mode 1: out <= (out >> WIDTH) with digit in slot COUNT-1; count+1.
- PUSH is rejected (err) if digit >= RADIX or full=1.
- PUSH of 0 with count=0 and LZ_SUPPRESS=1: ack, with no change to out or count.
- POP, mode 0: out <= out >> WIDTH, with the top slot zero-filled; count-1.
- POP, mode 1: out <= out << WIDTH, with slot 0 zero-filled; count-1.
- POP with empty=1: err.
- LOAD: rejected (err) if any slot of load_val >= RADIX. Otherwise out <= load_val and mode <= 0.
- LOAD count = index of the highest nonzero slot + 1, or 0 if all slots are zero. This holds for either LZ_SUPPRESS value.
- CLEAR: out <= 0, count <= 0, mode <= dir; always ack.
- empty and full are registered and consistent with count in the same cycle.
- The count arithmetic never wraps. Boundary cases are rejected before the update.

## Timing
- A command sampled at rising edge N updates out, count, empty and full at edge N.
- ack/err are high for exactly the cycle following edge N, then return to 0 unless another command is accepted or rejected.
- Back-to-back commands on consecutive cycles are supported. Each command sees the state left by the previous one; no bubble is required.
- reset dominates cmd_valid in the same cycle: reset state is produced and ack=err=0.
- Reset asserted mid-entry discards all digits and returns mode to 0.
- A change on dir has no effect except in a cycle with a valid CLEAR.

## Structure
- Shared package ip_pkg holds the cmd_e enum (PUSH, POP, LOAD, CLEAR) and the default RADIX constant, used by the keypad decoder too.
- One sub-module: digit_count_enc. It is a combinational priority encoder over COUNT slots, producing the LOAD count and a per-slot validity vector (slot < RADIX).
- All remaining logic is in digit_entry_reg: the command decode and the out/count/mode/ack/err registers.

## Test plan
Defaults: COUNT=4, WIDTH=4, RADIX=10, LZ_SUPPRESS=1.
- Reset, then PUSH 1,2,3,4 in mode 0 -> out=16'h1234, count=4, full=1. A fifth PUSH 5 -> err=1, out still 16'h1234.
- From 16'h1234, POP twice -> out=16'h0012, count=2. Three more POPs -> out=0, empty=1; the third POP gives err=1.
- CLEAR with dir=1, then PUSH 7,8 -> out=16'h8700, count=2. POP -> out=16'h7000, count=1.
- PUSH 0 when empty -> ack=1, count=0. PUSH 10 (4'hA) -> err=1, state unchanged.
- LOAD 16'h0305 -> count=3, ack=1. LOAD 16'h00B1 -> err=1, out still 16'h0305.
- cmd_valid=1 with reset=1 -> out=0, ack=err=0. Alternating PUSH/POP on consecutive cycles keeps count consistent.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared Input Unit definitions: command codes and the default digit radix.
// Used by the digit-entry register and the keypad decoder.
package ip_pkg;

   typedef enum logic [1:0] {
      CmdPush  = 2'd0,
      CmdPop   = 2'd1,
      CmdLoad  = 2'd2,
      CmdClear = 2'd3
   } cmd_e;

   localparam int unsigned DefaultRadix = 10;

endpackage

// File: rtl/digit_count_enc.sv
// Combinational priority encoder over the slots of a LOAD word: significant-digit
// count (highest nonzero slot + 1) and per-slot digit legality.
module digit_count_enc
   import ip_pkg::*;
#(
   parameter int unsigned COUNT = 4,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned RADIX = DefaultRadix
) (
   input  logic [COUNT*WIDTH-1:0]     load_val,
   output logic [$clog2(COUNT+1)-1:0] load_count,
   output logic [COUNT-1:0]           slot_ok
);

   localparam int unsigned CW = $clog2(COUNT + 1);

   always_comb begin
      load_count = '0;
      slot_ok    = '0;
      // Ascending scan so the highest nonzero slot wins.
      for (int i = 0; i < COUNT; i++) begin
         slot_ok[i] = 32'(load_val[i*WIDTH +: WIDTH]) < RADIX;
         if (load_val[i*WIDTH +: WIDTH] != '0) begin
            load_count = CW'(i + 1);
         end
      end
   end

endmodule

// File: rtl/digit_entry_reg.sv
// Digit-entry register: push/pop/load/clear of up to COUNT digits with count tracking,
// digit and bound checking, and optional leading-zero suppression.
module digit_entry_reg
   import ip_pkg::*;
#(
   parameter int unsigned COUNT       = 4,
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned RADIX       = DefaultRadix,
   parameter bit          LZ_SUPPRESS = 1'b1
) (
   input  logic                       trig,
   input  logic                       reset,
   input  logic                       cmd_valid,
   input  logic [1:0]                 cmd,
   input  logic                       dir,
   input  logic [WIDTH-1:0]           digit,
   input  logic [COUNT*WIDTH-1:0]     load_val,
   output logic [COUNT*WIDTH-1:0]     out,
   output logic [$clog2(COUNT+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       ack,
   output logic                       err
);

   localparam int unsigned CW = $clog2(COUNT + 1);
   localparam int unsigned DW = COUNT * WIDTH;

   logic [DW-1:0]    out_d, out_q;
   logic [CW-1:0]    count_d, count_q;
   logic             mode_d, mode_q;
   logic             empty_d, empty_q;
   logic             full_d, full_q;
   logic             ack_d, ack_q;
   logic             err_d, err_q;

   logic [CW-1:0]    load_count;
   logic [COUNT-1:0] slot_ok;
   logic             digit_ok;

   digit_count_enc #(
      .COUNT (COUNT),
      .WIDTH (WIDTH),
      .RADIX (RADIX)
   ) u_count_enc (
      .load_val   (load_val),
      .load_count (load_count),
      .slot_ok    (slot_ok)
   );

   assign digit_ok = 32'(digit) < RADIX;

   always_comb begin
      out_d   = out_q;
      count_d = count_q;
      mode_d  = mode_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      if (cmd_valid) begin
         case (cmd_e'(cmd))
            CmdPush: begin
               if (!digit_ok || full_q) begin
                  err_d = 1'b1;
               end else if (LZ_SUPPRESS && (digit == '0) && (count_q == '0)) begin
                  ack_d = 1'b1;
               end else begin
                  ack_d = 1'b1;
                  if (!mode_q) begin
                     out_d              = out_q << WIDTH;
                     out_d[WIDTH-1:0]   = digit;
                  end else begin
                     out_d              = out_q >> WIDTH;
                     out_d[DW-1 -: WIDTH] = digit;
                  end
                  count_d = count_q + CW'(1);
               end
            end
            CmdPop: begin
               if (empty_q) begin
                  err_d = 1'b1;
               end else begin
                  ack_d   = 1'b1;
                  out_d   = mode_q ? (out_q << WIDTH) : (out_q >> WIDTH);
                  count_d = count_q - CW'(1);
               end
            end
            CmdLoad: begin
               if (!(&slot_ok)) begin
                  err_d = 1'b1;
               end else begin
                  ack_d   = 1'b1;
                  out_d   = load_val;
                  count_d = load_count;
                  mode_d  = 1'b0;
               end
            end
            default: begin
               ack_d   = 1'b1;
               out_d   = '0;
               count_d = '0;
               mode_d  = dir;
            end
         endcase
      end
      // Flags track the next count so they stay coherent with count every cycle.
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(COUNT));
   end

   always_ff @(posedge trig) begin
      if (reset) begin
         out_q   <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign out   = out_q;
   assign count = count_q;
   assign empty = empty_q;
   assign full  = full_q;
   assign ack   = ack_q;
   assign err   = err_q;

endmodule

// File: tb/tb_digit_entry_reg.sv
// Self-checking bench for digit_entry_reg: directed scenarios followed by random
// commands compared against a slot-array reference model.
module tb_digit_entry_reg;
   import ip_pkg::*;

   localparam int unsigned COUNT = 4;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned RADIX = 10;
   localparam bit          LZ    = 1'b1;
   localparam int unsigned DW    = COUNT * WIDTH;
   localparam int unsigned CW    = $clog2(COUNT + 1);

   logic              trig = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic [1:0]        cmd;
   logic              dir;
   logic [WIDTH-1:0]  digit;
   logic [DW-1:0]     load_val;
   logic [DW-1:0]     dut_out;
   logic [CW-1:0]     dut_count;
   logic              dut_empty, dut_full, dut_ack, dut_err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: digit slots, significant count, entry mode.
   logic [WIDTH-1:0] m_slot [COUNT];
   int               m_cnt;
   bit               m_mode;
   bit               exp_ack, exp_err;

   digit_entry_reg #(
      .COUNT       (COUNT),
      .WIDTH       (WIDTH),
      .RADIX       (RADIX),
      .LZ_SUPPRESS (LZ)
   ) dut (
      .trig      (trig),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .dir       (dir),
      .digit     (digit),
      .load_val  (load_val),
      .out       (dut_out),
      .count     (dut_count),
      .empty     (dut_empty),
      .full      (dut_full),
      .ack       (dut_ack),
      .err       (dut_err)
   );

   always #5 trig = ~trig;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] model_word();
      logic [DW-1:0] w = '0;
      for (int i = 0; i < COUNT; i++) w[i*WIDTH +: WIDTH] = m_slot[i];
      return w;
   endfunction

   function automatic void model_apply(input bit rst, input bit v, input logic [1:0] c,
                                       input bit dr, input logic [WIDTH-1:0] dg,
                                       input logic [DW-1:0] lv);
      bit bad;
      int hi;
      exp_ack = 1'b0;
      exp_err = 1'b0;
      if (rst) begin
         for (int i = 0; i < COUNT; i++) m_slot[i] = '0;
         m_cnt  = 0;
         m_mode = 1'b0;
         return;
      end
      if (!v) return;
      case (c)
         2'd0: begin
            if (int'(dg) >= int'(RADIX) || m_cnt == int'(COUNT)) exp_err = 1'b1;
            else if (LZ && dg == 0 && m_cnt == 0) exp_ack = 1'b1;
            else begin
               exp_ack = 1'b1;
               if (!m_mode) begin
                  for (int i = COUNT - 1; i > 0; i--) m_slot[i] = m_slot[i-1];
                  m_slot[0] = dg;
               end else begin
                  for (int i = 0; i < COUNT - 1; i++) m_slot[i] = m_slot[i+1];
                  m_slot[COUNT-1] = dg;
               end
               m_cnt++;
            end
         end
         2'd1: begin
            if (m_cnt == 0) exp_err = 1'b1;
            else begin
               exp_ack = 1'b1;
               if (!m_mode) begin
                  for (int i = 0; i < COUNT - 1; i++) m_slot[i] = m_slot[i+1];
                  m_slot[COUNT-1] = '0;
               end else begin
                  for (int i = COUNT - 1; i > 0; i--) m_slot[i] = m_slot[i-1];
                  m_slot[0] = '0;
               end
               m_cnt--;
            end
         end
         2'd2: begin
            bad = 1'b0;
            hi  = 0;
            for (int i = 0; i < COUNT; i++) begin
               if (int'(lv[i*WIDTH +: WIDTH]) >= int'(RADIX)) bad = 1'b1;
               if (lv[i*WIDTH +: WIDTH] != 0) hi = i + 1;
            end
            if (bad) exp_err = 1'b1;
            else begin
               exp_ack = 1'b1;
               for (int i = 0; i < COUNT; i++) m_slot[i] = lv[i*WIDTH +: WIDTH];
               m_cnt  = hi;
               m_mode = 1'b0;
            end
         end
         default: begin
            exp_ack = 1'b1;
            for (int i = 0; i < COUNT; i++) m_slot[i] = '0;
            m_cnt  = 0;
            m_mode = dr;
         end
      endcase
   endfunction

   // Drive one cycle of inputs, advance the model, then check every output.
   task automatic step(input string tag, input bit rst, input bit v, input logic [1:0] c,
                       input bit dr, input logic [WIDTH-1:0] dg, input logic [DW-1:0] lv);
      reset     = rst;
      cmd_valid = v;
      cmd       = c;
      dir       = dr;
      digit     = dg;
      load_val  = lv;
      model_apply(rst, v, c, dr, dg, lv);
      @(posedge trig);
      #1;
      chk({tag, ".out"},   32'(dut_out),   32'(model_word()));
      chk({tag, ".count"}, 32'(dut_count), 32'(m_cnt));
      chk({tag, ".empty"}, 32'(dut_empty), 32'(m_cnt == 0));
      chk({tag, ".full"},  32'(dut_full),  32'(m_cnt == int'(COUNT)));
      chk({tag, ".ack"},   32'(dut_ack),   32'(exp_ack));
      chk({tag, ".err"},   32'(dut_err),   32'(exp_err));
   endtask

   task automatic push(input string tag, input logic [WIDTH-1:0] dg);
      step(tag, 1'b0, 1'b1, CmdPush, 1'($urandom_range(0, 1)), dg, '0);
   endtask

   task automatic pop(input string tag);
      step(tag, 1'b0, 1'b1, CmdPop, 1'($urandom_range(0, 1)), '0, '0);
   endtask

   initial begin
      logic [DW-1:0]    lv;
      logic [WIDTH-1:0] dg;
      logic [1:0]       c;

      reset = 1'b1; cmd_valid = 1'b0; cmd = '0; dir = 1'b0; digit = '0; load_val = '0;
      #1;
      step("reset", 1'b1, 1'b0, CmdPush, 1'b0, '0, '0);
      chk("reset.out_const", 32'(dut_out), 32'h0);
      chk("reset.empty_const", 32'(dut_empty), 32'd1);

      // Mode 0 entry to full, then overflow.
      push("push1", 4'd1);
      push("push2", 4'd2);
      push("push3", 4'd3);
      push("push4", 4'd4);
      chk("push4.word", 32'(dut_out), 32'h1234);
      chk("push4.fullc", 32'(dut_full), 32'd1);
      push("push5_ovf", 4'd5);
      chk("ovf.word", 32'(dut_out), 32'h1234);
      chk("ovf.errc", 32'(dut_err), 32'd1);

      // Backspace to empty, then underflow.
      pop("pop1");
      pop("pop2");
      chk("pop2.word", 32'(dut_out), 32'h0012);
      pop("pop3");
      pop("pop4");
      pop("pop5_udf");
      chk("udf.errc", 32'(dut_err), 32'd1);
      chk("udf.word", 32'(dut_out), 32'h0);

      // Mode 1 entry.
      step("clr_dir1", 1'b0, 1'b1, CmdClear, 1'b1, '0, '0);
      push("m1_push7", 4'd7);
      push("m1_push8", 4'd8);
      chk("m1.word", 32'(dut_out), 32'h8700);
      pop("m1_pop");
      chk("m1pop.word", 32'(dut_out), 32'h7000);

      // Leading zero and illegal digit.
      step("clr_dir0", 1'b0, 1'b1, CmdClear, 1'b0, '0, '0);
      push("lz_push0", 4'd0);
      chk("lz.ackc", 32'(dut_ack), 32'd1);
      push("bad_digit", 4'hA);
      chk("bad.errc", 32'(dut_err), 32'd1);

      // Parallel load, legal then illegal.
      step("load_ok", 1'b0, 1'b1, CmdLoad, 1'b1, '0, 16'h0305);
      chk("load.cntc", 32'(dut_count), 32'd3);
      step("load_bad", 1'b0, 1'b1, CmdLoad, 1'b0, '0, 16'h00B1);
      chk("loadbad.word", 32'(dut_out), 32'h0305);

      // Reset dominates a valid command.
      step("rst_cmd", 1'b1, 1'b1, CmdPush, 1'b0, 4'd5, '0);
      chk("rstcmd.ackc", 32'(dut_ack), 32'd0);

      // Back-to-back alternating push/pop.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) push("alt_push", WIDTH'(i + 1));
         else pop("alt_pop");
      end
      step("idle", 1'b0, 1'b0, CmdPush, 1'b0, '0, '0);

      // Random command stream.
      for (int n = 0; n < 400; n++) begin
         c  = 2'($urandom_range(0, 3));
         dg = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(10, 15))
                                           : WIDTH'($urandom_range(0, 9));
         lv = '0;
         for (int i = 0; i < COUNT; i++) begin
            if ($urandom_range(0, 9) == 0) lv[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(10, 15));
            else if ($urandom_range(0, 2) != 0) lv[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
         end
         // Bias toward push so full is reached regularly.
         if ($urandom_range(0, 3) == 0) c = CmdPush;
         if (c == CmdClear && $urandom_range(0, 1) == 0) c = CmdPop;
         step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), c,
              1'($urandom_range(0, 1)), dg, lv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
